// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants: request op enum, opcodes, funct codes, field positions
// and word-packing helpers. The control-unit decode uses the same constants.
package mips_isa_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOR  = 4'd5,
    OP_SLT  = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_LW   = 4'd9,
    OP_SW   = 4'd10,
    OP_BEQ  = 4'd11,
    OP_J    = 4'd12,
    OP_ADDI = 4'd13
  } in_op_e;

  localparam logic [5:0] OPC_R    = 6'h00;
  localparam logic [5:0] OPC_LW   = 6'h23;
  localparam logic [5:0] OPC_SW   = 6'h2B;
  localparam logic [5:0] OPC_BEQ  = 6'h04;
  localparam logic [5:0] OPC_J    = 6'h02;
  localparam logic [5:0] OPC_ADDI = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;

  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned SHAMT_LSB = 6;
  localparam int unsigned FUNCT_LSB = 0;
  localparam int unsigned IMM_LSB   = 0;
  localparam int unsigned TGT_LSB   = 0;

  function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] shamt,
                                         input logic [5:0] funct);
    logic [31:0] w;
    w = '0;
    w[OP_LSB    +: 6] = OPC_R;
    w[RS_LSB    +: 5] = rs;
    w[RT_LSB    +: 5] = rt;
    w[RD_LSB    +: 5] = rd;
    w[SHAMT_LSB +: 5] = shamt;
    w[FUNCT_LSB +: 6] = funct;
    return w;
  endfunction

  function automatic logic [31:0] pack_i(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    logic [31:0] w;
    w = '0;
    w[OP_LSB  +: 6]  = opc;
    w[RS_LSB  +: 5]  = rs;
    w[RT_LSB  +: 5]  = rt;
    w[IMM_LSB +: 16] = imm;
    return w;
  endfunction

  function automatic logic [31:0] pack_j(input logic [25:0] target);
    logic [31:0] w;
    w = '0;
    w[OP_LSB  +: 6]  = OPC_J;
    w[TGT_LSB +: 26] = target;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags; push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      occ;
  logic             do_push, do_pop;

  assign full    = (occ == FULL_OCC);
  assign empty   = (occ == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Packs field-level MIPS requests into 32-bit words and streams them into instruction
// memory from BASE_ADDR. Optional request checking: define INSTR_ENC_CHECK_EN.
module instr_encoder_loader
  import mips_isa_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e      state, state_nxt;
  logic        last_seen;
  logic        fifo_full, fifo_empty, fifo_push;
  logic        accept, mem_pop, start_run;
  logic [31:0] enc_word;

  assign accept    = in_valid && in_ready;
  assign mem_pop   = mem_we && mem_ready;
  assign start_run = (state == S_IDLE) && start;

  // Shifts take rs as 0; other R-types take shamt as 0.
  always_comb begin
    enc_word = '0;
    case (in_op)
      OP_ADD:  enc_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FN_ADD);
      OP_SUB:  enc_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FN_SUB);
      OP_AND:  enc_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FN_AND);
      OP_OR:   enc_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FN_OR);
      OP_XOR:  enc_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FN_XOR);
      OP_NOR:  enc_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FN_NOR);
      OP_SLT:  enc_word = pack_r(in_rs, in_rt, in_rd, 5'd0, FN_SLT);
      OP_SLL:  enc_word = pack_r(5'd0, in_rt, in_rd, in_shamt, FN_SLL);
      OP_SRL:  enc_word = pack_r(5'd0, in_rt, in_rd, in_shamt, FN_SRL);
      OP_LW:   enc_word = pack_i(OPC_LW, in_rs, in_rt, in_imm);
      OP_SW:   enc_word = pack_i(OPC_SW, in_rs, in_rt, in_imm);
      OP_BEQ:  enc_word = pack_i(OPC_BEQ, in_rs, in_rt, in_imm);
      OP_J:    enc_word = pack_j(in_target);
      OP_ADDI: enc_word = pack_i(OPC_ADDI, in_rs, in_rt, in_imm);
      default: enc_word = '0;
    endcase
  end

`ifdef INSTR_ENC_CHECK_EN
  logic req_bad;
  logic err_q;

  assign req_bad   = (in_op >= 4'd14) || ((in_op <= OP_SLT) && (in_shamt != '0));
  assign fifo_push = accept && !req_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                err_q <= 1'b0;
    else if (start_run)        err_q <= 1'b0;
    else if (accept && req_bad) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign fifo_push = accept;
  assign err       = 1'b0;
`endif

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (enc_word),
    .pop   (mem_pop),
    .dout  (mem_wdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // An empty FIFO implies no write is outstanding: mem_we only asserts when non-empty.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_seen && fifo_empty) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
    in_ready = (state == S_RUN) && !fifo_full && !last_seen;
    mem_we   = (state == S_RUN) && !fifo_empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= ADDR_W'(BASE_ADDR);
      count     <= '0;
      last_seen <= 1'b0;
    end else if (start_run) begin
      mem_addr  <= ADDR_W'(BASE_ADDR);
      count     <= '0;
      last_seen <= 1'b0;
    end else begin
      if (mem_pop) begin
        mem_addr <= mem_addr + 1'b1;
        if (count != '1) count <= count + 1'b1;
      end
      if (accept && in_last) last_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench: table-driven encode vectors plus hand-written backpressure,
// address-wrap, illegal-request and mid-session reset sequences.
module tb_instr_encoder_loader;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n, start, start2, in_valid, in_last, mem_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;

  logic        in_ready, mem_we, busy, done, err;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [10:0] count;

  logic        in_ready2, mem_we2, busy2, done2, err2;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_wdata2;
  logic [2:0]  count2;

  int errors = 0;
  int checks = 0;
  int acc_n  = 0;
  wr_t  wr_q[$];
  wr_t  wr2_q[$];
  vec_t tbl[15];

  always #5 clk = ~clk;

  instr_encoder_loader #(.DEPTH(4), .ADDR_W(10), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target), .in_last(in_last), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready), .busy(busy),
    .done(done), .count(count), .err(err)
  );

  instr_encoder_loader #(.DEPTH(4), .ADDR_W(2), .BASE_ADDR(3)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid), .in_ready(in_ready2),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target), .in_last(in_last), .mem_we(mem_we2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_ready(mem_ready), .busy(busy2),
    .done(done2), .count(count2), .err(err2)
  );

  always @(negedge clk) begin
    if (mem_we && mem_ready)   wr_q.push_back('{mem_addr, mem_wdata});
    if (mem_we2 && mem_ready)  wr2_q.push_back('{{8'b0, mem_addr2}, mem_wdata2});
    if (in_valid && in_ready)  acc_n++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_note(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic start_pulse(input bit sel);
    @(posedge clk); #1;
    if (sel) start2 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic send(input vec_t v, input bit last, input bit sel);
    int n;
    in_op = v.op; in_rs = v.rs; in_rt = v.rt; in_rd = v.rd; in_shamt = v.shamt;
    in_imm = v.imm; in_target = v.target; in_last = last; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (sel ? in_ready2 : in_ready) break;
      n++;
      if (n > 60) begin
        fail_note("send_timeout");
        in_valid = 1'b0;
        in_last = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_done(input bit sel);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sel ? done2 : done) return;
    end
    fail_note("done_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    bit   stable;

    tbl[0]  = '{4'd9,  5'd9,  5'd8,  5'd0,  5'd0,  16'h0004, 26'd0,        32'h8D280004}; // LW
    tbl[1]  = '{4'd7,  5'd0,  5'd1,  5'd2,  5'd4,  16'h0000, 26'd0,        32'h00011100}; // SLL
    tbl[2]  = '{4'd11, 5'd1,  5'd2,  5'd0,  5'd0,  16'hFFFF, 26'd0,        32'h1022FFFF}; // BEQ
    tbl[3]  = '{4'd12, 5'd0,  5'd0,  5'd0,  5'd0,  16'h0000, 26'h0000100,  32'h08000100}; // J
    tbl[4]  = '{4'd0,  5'd1,  5'd2,  5'd3,  5'd0,  16'h0000, 26'd0,        32'h00221820}; // ADD
    tbl[5]  = '{4'd1,  5'd4,  5'd5,  5'd6,  5'd0,  16'h0000, 26'd0,        32'h00853022}; // SUB
    tbl[6]  = '{4'd2,  5'd7,  5'd8,  5'd9,  5'd0,  16'h0000, 26'd0,        32'h00E84824}; // AND
    tbl[7]  = '{4'd3,  5'd10, 5'd11, 5'd12, 5'd0,  16'h0000, 26'd0,        32'h014B6025}; // OR
    tbl[8]  = '{4'd4,  5'd13, 5'd14, 5'd15, 5'd0,  16'h0000, 26'd0,        32'h01AE7826}; // XOR
    tbl[9]  = '{4'd5,  5'd16, 5'd17, 5'd18, 5'd0,  16'h0000, 26'd0,        32'h02119027}; // NOR
    tbl[10] = '{4'd6,  5'd31, 5'd31, 5'd31, 5'd0,  16'h0000, 26'd0,        32'h03FFF82A}; // SLT
    tbl[11] = '{4'd8,  5'd5,  5'd3,  5'd4,  5'd31, 16'h0000, 26'd0,        32'h000327C2}; // SRL, rs forced 0
    tbl[12] = '{4'd10, 5'd29, 5'd31, 5'd0,  5'd0,  16'h8000, 26'd0,        32'hAFBF8000}; // SW
    tbl[13] = '{4'd13, 5'd2,  5'd3,  5'd0,  5'd0,  16'h1234, 26'd0,        32'h20431234}; // ADDI
    tbl[14] = '{4'd12, 5'd5,  5'd0,  5'd0,  5'd0,  16'h0000, 26'h3FFFFFF,  32'h0BFFFFFF}; // J max

    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    mem_ready = 1'b1; in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
    in_imm = '0; in_target = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_count", count, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wrap_addr", mem_addr2, 3);
    rst_n = 1'b1;

    // Single ADD with exact done/busy timing.
    wr_q.delete();
    start_pulse(0);
    chk("run_busy", busy, 1);
    send(tbl[4], 1'b1, 0);
    @(negedge clk); chk("enc_latency_we", mem_we, 1); chk("enc_done_c1", done, 0);
    @(negedge clk); chk("enc_done_c2", done, 0);
    @(negedge clk); chk("enc_done_pulse", done, 1); chk("enc_busy_in_done", busy, 1);
    @(negedge clk); chk("enc_done_fall", done, 0); chk("enc_busy_fall", busy, 0);
    chk("enc_nwrites", wr_q.size(), 1);
    if (wr_q.size() > 0) begin
      chk("enc_addr", wr_q[0].a, 0);
      chk("enc_data", wr_q[0].d, 32'h00221820);
    end
    chk("enc_count", count, 1);

    // Full table in one session; the first four are the field-mix sequence.
    wr_q.delete();
    start_pulse(0);
    for (int i = 0; i < 15; i++) send(tbl[i], i == 14, 0);
    wait_done(0);
    @(negedge clk);
    chk("tbl_nwrites", wr_q.size(), 15);
    for (int i = 0; i < 15; i++) begin
      if (i < wr_q.size()) begin
        chk($sformatf("tbl_addr_%0d", i), wr_q[i].a, i);
        chk($sformatf("tbl_data_%0d", i), wr_q[i].d, tbl[i].exp);
      end
    end
    chk("tbl_count", count, 15);
    chk("tbl_err", err, 0);

    // Backpressure: memory stalled for 10 cycles while 6 requests stream in.
    mem_ready = 1'b0;
    wr_q.delete();
    start_pulse(0);
    acc_n = 0;
    stable = 1'b1;
    fork
      for (int i = 0; i < 6; i++) send(tbl[4+i], i == 5, 0);
      begin
        repeat (10) begin
          @(negedge clk);
          if (mem_we && (mem_wdata !== tbl[4].exp || mem_addr !== 10'd0)) stable = 1'b0;
        end
        chk("bp_accepts", acc_n, 4);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_mem_we", mem_we, 1);
        chk("bp_hold_stable", stable, 1);
        mem_ready = 1'b1;
      end
    join
    wait_done(0);
    @(negedge clk);
    chk("bp_nwrites", wr_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < wr_q.size()) begin
        chk($sformatf("bp_addr_%0d", i), wr_q[i].a, i);
        chk($sformatf("bp_data_%0d", i), wr_q[i].d, tbl[4+i].exp);
      end
    end

    // Address wrap on the ADDR_W=2, BASE_ADDR=3 instance.
    wr2_q.delete();
    start_pulse(1);
    for (int i = 0; i < 3; i++) send(tbl[i], i == 2, 1);
    wait_done(1);
    @(negedge clk);
    chk("wrap_nwrites", wr2_q.size(), 3);
    if (wr2_q.size() == 3) begin
      chk("wrap_addr0", wr2_q[0].a, 3);
      chk("wrap_addr1", wr2_q[1].a, 0);
      chk("wrap_addr2", wr2_q[2].a, 1);
      chk("wrap_data2", wr2_q[2].d, tbl[2].exp);
    end
    chk("wrap_count", count2, 3);

    // Non-shift op with shamt, then illegal op 14 as last.
    wr_q.delete();
    start_pulse(0);
    v = tbl[4];
    v.shamt = 5'd5;
    send(v, 1'b0, 0);
    v = tbl[4];
    v.op = 4'd14;
    send(v, 1'b1, 0);
    wait_done(0);
    @(negedge clk);
`ifdef INSTR_ENC_CHECK_EN
    chk("ill_nwrites", wr_q.size(), 0);
    chk("ill_err", err, 1);
`else
    chk("ill_nwrites", wr_q.size(), 2);
    if (wr_q.size() == 2) begin
      chk("ill_shamt_masked", wr_q[0].d, 32'h00221820);
      chk("ill_nop", wr_q[1].d, 32'h00000000);
    end
    chk("ill_err", err, 0);
`endif

    // Reset mid-session with two entries queued.
    mem_ready = 1'b0;
    start_pulse(0);
    send(tbl[0], 1'b0, 0);
    send(tbl[1], 1'b0, 0);
    @(negedge clk);
    chk("mid_queued_we", mem_we, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    wr_q.delete();
    start_pulse(0);
    send(tbl[3], 1'b1, 0);
    wait_done(0);
    @(negedge clk);
    chk("mid_nwrites", wr_q.size(), 1);
    if (wr_q.size() > 0) begin
      chk("mid_addr", wr_q[0].a, 0);
      chk("mid_data", wr_q[0].d, 32'h08000100);
    end
    chk("mid_count", count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Sequential MIPS instruction encoder and program loader, the inverse of the decode path. It accepts field-level instruction requests over a valid/ready handshake and packs them into 32-bit MIPS words. Words are buffered in a small FIFO and written sequentially into instruction memory starting at a base address. It is used to boot-load or patch the I-cache backing store, producing exactly the opcode/funct set the control unit decodes.

## Interface
- `DEPTH`, 4: FIFO entries (power of two, ≥2).
- `ADDR_W`, 10: word-address width.
- `BASE_ADDR`, 0: first word address written after `start`.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a load session; ignored unless in IDLE.
- `in_valid` in 1: request valid.
- `in_ready` out 1: request accepted when `in_valid && in_ready`.
- `in_op` in 4: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLL, 8 SRL, 9 LW, 10 SW, 11 BEQ, 12 J, 13 ADDI; 14–15 illegal.
- `in_rs`, `in_rt`, `in_rd`, `in_shamt` in 5 each: register and shift fields.
- `in_imm` in 16: I-type immediate, raw bits.
- `in_target` in 26: J-type target.
- `in_last` in 1: final request of the session.
- `mem_we` out 1: write strobe.
- `mem_addr` out ADDR_W: word address.
- `mem_wdata` out 32: encoded word.
- `mem_ready` in 1: memory accepts the write this cycle when `mem_we && mem_ready`.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse at session completion.
- `count` out ADDR_W+1: words written this session, saturating.
- `err` out 1: sticky illegal-request flag. Exists only with the check macro; otherwise tied 0.

## Operation
- FSM states:
  - IDLE → RUN on `start`. Entering RUN clears `count` and `err`, loads `mem_addr` with BASE_ADDR, and clears `last_seen`.
  - RUN → DONE when `last_seen` is set, the FIFO is empty, and no write is outstanding.
  - DONE → IDLE unconditionally. `done` is high only in DONE.
- `in_ready` = RUN && !full && !last_seen. There is no same-cycle bypass when full.
- Encoding is combinational at the input; the FIFO stores the 32-bit word.
  - R-type: {6'h00, rs, rt, rd, shamt, funct}. funct values: ADD 20, SUB 22, AND 24, OR 25, XOR 26, NOR 27, SLT 2A, SLL 00, SRL 02 (hex).
  - SLL and SRL force the rs field to 0.
  - I-type: {op, rs, rt, imm}. Opcodes: LW 23, SW 2B, BEQ 04, ADDI 08 (hex).
  - J-type: {6'h02, target}.
- Drain side: `mem_we` = RUN && !empty, with `mem_wdata` = FIFO head.
  - On `mem_ready`: pop, increment `mem_addr` by 1 modulo 2^ADDR_W (wraps silently), and increment `count`, saturating at all-ones.
- Accepting `in_last` sets `last_seen`, which holds until the next `start`.
- Simultaneous push and pop in the same cycle keeps the occupancy unchanged.
- `start` while busy has no effect.
- Reset mid-session forces IDLE and an empty FIFO. Reset values: `mem_we`=0, `mem_addr`=BASE_ADDR, `count`=0, `err`=0, `in_ready`=0, `busy`=0, `done`=0.

## Timing
- A word accepted in cycle N is presented on `mem_we` no earlier than N+1.
- With `mem_ready` held high: sustained throughput is one word per cycle. `done` pulses 2 cycles after the last accepted handshake.
- `mem_addr` and `mem_wdata` hold stable while `mem_we && !mem_ready`.
- `busy` falls in the same cycle the FSM returns to IDLE, one cycle after `done`.

## Configuration
- Macro: `INSTR_ENC_CHECK_EN`.
- Defined: a request is illegal if `in_op` is 14–15, or if it is a non-shift R-type op with nonzero `in_shamt`.
  - The handshake still completes but nothing is pushed, and `err` sets (sticky until the next `start`).
  - `in_last` on a dropped request is still honoured.
- Undefined: op 14–15 encodes as 32'h00000000 (NOP), and shamt is masked to 0 for non-shift ops. `err` is constant 0.

## Structure
- Shared package `mips_isa_pkg` holds:
  - the `in_op` enum;
  - the opcode constants (R, LW, SW, BEQ, J, ADDI);
  - the funct constants;
  - the field-position localparams.
  
  The control unit decode should use the same constants.
- One sub-module, `sync_fifo`, parameterised for width and depth, with full/empty flags. The encoder logic stays in the top module.

## Test plan
- Encode check: start, then ADD rs=1 rt=2 rd=3 last=1 → one write, `mem_addr`=0, `mem_wdata`=32'h00221820, `done` pulse, `count`=1.
- Field mix: LW rs=9 rt=8 imm=4; SLL rt=1 rd=2 shamt=4; BEQ rs=1 rt=2 imm=FFFF; J target=100 (hex) → 8D280004, 00011100, 1022FFFF, 08000100 at addresses 0–3.
- Backpressure: `mem_ready`=0 for 10 cycles while streaming 6 requests → `in_ready` drops after 4 accepts (DEPTH=4), `mem_wdata` is held stable, and all 6 words are later written in order.
- Wrap: ADDR_W=2, BASE_ADDR=3, 3 words → addresses 3, 0, 1.
- Illegal: `in_op`=14 sent as last.
  - With the macro: no write, `err`=1, `done` pulses.
  - Without the macro: 32'h00000000 is written.
- Reset mid-session: deassert `rst_n` with 2 entries queued → `mem_we`=0 immediately, FIFO empty, IDLE, and `start` afterwards rewrites from BASE_ADDR.
